// File: rtl/rvvi_rx_pkg.sv
// Shared types and constants for the RVVI trace receiver.
// rvvi_rec_t is one buffered retirement/trap event.
package rvvi_rx_pkg;

  localparam int unsigned ORDER_W  = 64;
  localparam int unsigned REC_ILEN = 32;
  localparam int unsigned REC_XLEN = 32;

  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [REC_ILEN-1:0] insn;
    logic [REC_XLEN-1:0] pc;
    logic                trap;
    logic [1:0]          mode;
  } rvvi_rec_t;

endpackage : rvvi_rx_pkg

// File: rtl/rvvi_rec_fifo.sv
// Synchronous FIFO of trace records with registered storage.
// The head entry is read combinationally from storage (no bypass).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   push_i / pop_i     enqueue / dequeue strobes
//   wdata_i            record to enqueue
//   rdata_o            head record
//   full_o / empty_o   derived from occupancy
//   level_o            current occupancy
module rvvi_rec_fifo
  import rvvi_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  rvvi_rec_t                  wdata_i,
  output rvvi_rec_t                  rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  rvvi_rec_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q,  level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard strobes so the FIFO can never over/underflow on its own.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage cleared on reset so the head reads as zero when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule : rvvi_rec_fifo

// File: rtl/rvvi_trace_receiver.sv
// RVVI trace consumer for one hart / one retire slot.
// Checks that the order field is gap-free, buffers events in a FIFO and
// hands them to a collector over valid/ready.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   trace_*                          incoming retirement/trap event
//   out_valid/out_ready, out_*       head-of-FIFO handshake and record
//   order_err                        one-cycle pulse on sequence violation
//   order_err_count                  saturating violation count
//   overflow                         sticky: event dropped because FIFO full
//   fill_level                       FIFO occupancy
module rvvi_trace_receiver
  import rvvi_rx_pkg::*;
#(
  parameter int unsigned ILEN  = 32,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_valid,
  input  logic [ORDER_W-1:0]         trace_order,
  input  logic [ILEN-1:0]            trace_insn,
  input  logic [XLEN-1:0]            trace_pc,
  input  logic                       trace_trap,
  input  logic [1:0]                 trace_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ORDER_W-1:0]         out_order,
  output logic [ILEN-1:0]            out_insn,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_trap,
  output logic [1:0]                 out_mode,
  output logic                       order_err,
  output logic [CNTW-1:0]            order_err_count,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fill_level
);

  rvvi_rec_t            rec_in, rec_head;
  logic                 fifo_full, fifo_empty;
  logic                 push_c, pop_c;

  logic                 seeded_q, seeded_d;
  logic [ORDER_W-1:0]   exp_q,    exp_d;
  logic                 err_q,    err_d;
  logic [CNTW-1:0]      cnt_q,    cnt_d;
  logic                 ovf_q,    ovf_d;

  always_comb begin
    rec_in       = '0;
    rec_in.order = trace_order;
    rec_in.insn  = trace_insn;
    rec_in.pc    = trace_pc;
    rec_in.trap  = trace_trap;
    rec_in.mode  = trace_mode;
  end

  assign pop_c  = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_c = trace_valid && (!fifo_full || pop_c);

  rvvi_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (rec_in),
    .rdata_o (rec_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fill_level)
  );

  assign out_valid = !fifo_empty;
  assign out_order = rec_head.order;
  assign out_insn  = rec_head.insn;
  assign out_pc    = rec_head.pc;
  assign out_trap  = rec_head.trap;
  assign out_mode  = rec_head.mode;

  // Sequence checker and overflow flag; every valid event is checked,
  // whether stored or dropped. Order arithmetic wraps modulo 2^64.
  always_comb begin
    seeded_d = seeded_q;
    exp_d    = exp_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (trace_valid) begin
      exp_d = trace_order + ORDER_W'(1);
      if (!seeded_q) begin
        seeded_d = 1'b1;
      end else if (trace_order != exp_q) begin
        err_d = 1'b1;
        if (!(&cnt_q)) cnt_d = cnt_q + CNTW'(1);
      end
      if (fifo_full && !pop_c) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seeded_q <= 1'b0;
      exp_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      seeded_q <= seeded_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign order_err       = err_q;
  assign order_err_count = cnt_q;
  assign overflow        = ovf_q;

endmodule : rvvi_trace_receiver
